// File: rtl/pool_if.sv
// Streaming handshake bundle for the pooling engine: one element per channel
// in, one pooled result per channel out.
interface pool_if #(
   parameter int CH = 64,
   parameter int DW = 32
);
   logic [CH-1:0][DW-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [CH-1:0][DW-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/pool_engine.sv
// Windowed max/average pooling across CH parallel channels. One shared
// control FSM and beat counter; each channel owns an accumulator lane.
module pool_lane #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld,
   input  logic          first,
   input  logic          last,
   input  logic          avg,
   input  logic [AW-1:0] shift,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);
   localparam int SW = DW + AW;

   logic signed [SW-1:0] acc, dx, nxt, sh;
   logic        [AW:0]   hi;
   logic        [DW-1:0] res;

   assign dx = {{AW{d[DW-1]}}, d};

   always_comb begin
      nxt = dx;
      if (!first) begin
         if (avg)          nxt = acc + dx;
         else if (dx > acc) nxt = dx;
         else              nxt = acc;
      end
   end

   // Floor shift, then saturate when the bits above DW-1 disagree with the sign.
   always_comb begin
      sh = nxt >>> shift;
      hi = sh[SW-1:DW-1];
      if (hi == {(AW+1){sh[SW-1]}}) res = sh[DW-1:0];
      else if (sh[SW-1])            res = {1'b1, {(DW-1){1'b0}}};
      else                          res = {1'b0, {(DW-1){1'b1}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         q   <= '0;
      end else if (ld) begin
         acc <= nxt;
         if (last) q <= avg ? res : nxt[DW-1:0];
      end
   end
endmodule

module pool_engine #(
   parameter int CH   = 64,
   parameter int DW   = 32,
   parameter int WMAX = 16,
   localparam int AW  = $clog2(WMAX) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic [AW-1:0] cfg_win,
   input  logic          cfg_avg,
   input  logic [AW-1:0] cfg_shift,
   pool_if.slave         bus
);
   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t                state;
   logic [AW-1:0]         cnt, cnt_inc, win_l, win_eff, tgt, shift_l, shift_s;
   logic                  avg_l, avg_s, rdy, vld;
   logic                  acc_ok, first, last, ld;
   logic [CH-1:0][DW-1:0] out_q;

   assign win_eff = (cfg_win == '0)          ? AW'(1)    :
                    (cfg_win > AW'(WMAX))    ? AW'(WMAX) : cfg_win;

   // The first beat of a window must use the live config since nothing is latched yet.
   assign acc_ok  = bus.in_valid & rdy;
   assign first   = acc_ok & (state == IDLE);
   assign cnt_inc = first ? AW'(1) : cnt + AW'(1);
   assign tgt     = first ? win_eff : win_l;
   assign last    = acc_ok & (cnt_inc == tgt);
   assign avg_s   = first ? cfg_avg : avg_l;
   assign shift_s = first ? cfg_shift : shift_l;
   assign ld      = acc_ok & ~clr;

   assign bus.in_ready  = rdy;
   assign bus.out_valid = vld;
   assign bus.out_data  = out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         rdy     <= 1'b0;
         vld     <= 1'b0;
         win_l   <= '0;
         avg_l   <= 1'b0;
         shift_l <= '0;
      end else if (clr) begin
         state <= IDLE;
         cnt   <= '0;
         rdy   <= 1'b1;
         vld   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rdy <= 1'b1;
               if (first) begin
                  win_l   <= win_eff;
                  avg_l   <= cfg_avg;
                  shift_l <= cfg_shift;
                  cnt     <= cnt_inc;
                  if (last) begin
                     state <= HOLD;
                     rdy   <= 1'b0;
                     vld   <= 1'b1;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            ACC: begin
               if (acc_ok) begin
                  cnt <= cnt_inc;
                  if (last) begin
                     state <= HOLD;
                     rdy   <= 1'b0;
                     vld   <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (vld && bus.out_ready) begin
                  state <= IDLE;
                  cnt   <= '0;
                  vld   <= 1'b0;
                  rdy   <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_lane
      pool_lane #(.DW(DW), .AW(AW)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .ld    (ld),
         .first (first),
         .last  (last),
         .avg   (avg_s),
         .shift (shift_s),
         .d     (bus.in_data[i]),
         .q     (out_q[i])
      );
   end
endmodule
